// File: rtl/shared_set_arb_pkg.sv
// Shared constants and helpers for the settings-bus arbiter.
// Optional input address filter is enabled by defining SHARED_SET_ARB_ADDR_FILTER_EN.
package shared_set_arb_pkg;

  function automatic int entry_width(input int aw, input int dw);
    return aw + dw;
  endfunction

  function automatic int src_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Pointer starts at the last channel so that channel 0 is searched first.
  function automatic int rr_reset(input int n);
    return n - 1;
  endfunction

endpackage

// File: rtl/set_bus_fifo.sv
// Single-clock FIFO of 2**AWIDTH entries with combinational head read.
// A push while full is accepted when the same cycle pops.
module set_bus_fifo #(
  parameter int WIDTH  = 40,
  parameter int AWIDTH = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << AWIDTH;

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [AWIDTH:0]   wr_ptr;
  logic [AWIDTH:0]   rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AWIDTH] != rd_ptr[AWIDTH]) &&
                   (wr_ptr[AWIDTH-1:0] == rd_ptr[AWIDTH-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AWIDTH-1:0]];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // When full, the write slot equals the slot being read this cycle; the read
  // sees the old entry because the write lands at the edge.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr[AWIDTH-1:0]] <= din;
  end

endmodule

// File: rtl/shared_set_bus_arbiter.sv
// Round-robin arbiter merging NUM_CHANNELS settings buses onto one ready-gated bus.
// Optional address filter: define SHARED_SET_ARB_ADDR_FILTER_EN.
module shared_set_bus_arbiter
  import shared_set_arb_pkg::*;
#(
  parameter int                NUM_CHANNELS = 2,
  parameter int                AWIDTH       = 8,
  parameter int                DWIDTH       = 32,
  parameter int                FIFO_AWIDTH  = 2,
  parameter logic [AWIDTH-1:0] ADDR_LO      = '0,
  parameter logic [AWIDTH-1:0] ADDR_HI      = '1
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             clear,
  input  logic [NUM_CHANNELS-1:0]          in_set_stb,
  input  logic [NUM_CHANNELS*AWIDTH-1:0]   in_set_addr,
  input  logic [NUM_CHANNELS*DWIDTH-1:0]   in_set_data,
  output logic                             out_set_stb,
  output logic [AWIDTH-1:0]                out_set_addr,
  output logic [DWIDTH-1:0]                out_set_data,
  output logic [src_width(NUM_CHANNELS)-1:0] out_set_src,
  input  logic                             out_ready,
  output logic [NUM_CHANNELS-1:0]          overflow,
  output logic                             busy
);

  localparam int EW = entry_width(AWIDTH, DWIDTH);
  localparam int SW = src_width(NUM_CHANNELS);
  localparam logic [SW-1:0]     LG_RST    = SW'(rr_reset(NUM_CHANNELS));
  localparam logic [AWIDTH-1:0] ADDR_SPAN = ADDR_HI - ADDR_LO;
`ifdef SHARED_SET_ARB_ADDR_FILTER_EN
  localparam bit FILTER_ON = 1'b1;
`else
  localparam bit FILTER_ON = 1'b0;
`endif

  logic [NUM_CHANNELS-1:0] in_range;
  logic [NUM_CHANNELS-1:0] push;
  logic [NUM_CHANNELS-1:0] pop;
  logic [NUM_CHANNELS-1:0] full;
  logic [NUM_CHANNELS-1:0] empty;
  logic [EW-1:0]           head [NUM_CHANNELS];
  logic [SW-1:0]           last_grant;
  logic [SW-1:0]           win;
  logic                    found;
  logic                    grant;

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_ch
    logic [AWIDTH-1:0] ch_addr;
    logic [AWIDTH-1:0] ch_off;
    assign ch_addr     = in_set_addr[AWIDTH*i +: AWIDTH];
    // Modular offset keeps the range test a single unsigned compare.
    assign ch_off      = ch_addr - ADDR_LO;
    assign in_range[i] = (ch_off <= ADDR_SPAN);
    assign push[i]     = in_set_stb[i] && (in_range[i] || !FILTER_ON);
    assign pop[i]      = grant && (win == SW'(i));

    set_bus_fifo #(
      .WIDTH (EW),
      .AWIDTH(FIFO_AWIDTH)
    ) u_fifo (
      .clk    (clk),
      .reset_n(reset_n),
      .clear  (clear),
      .push   (push[i]),
      .din    ({ch_addr, in_set_data[DWIDTH*i +: DWIDTH]}),
      .pop    (pop[i]),
      .dout   (head[i]),
      .full   (full[i]),
      .empty  (empty[i])
    );
  end

  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int k = 1; k <= NUM_CHANNELS; k++) begin
      if (!found && !empty[(int'(last_grant) + k) % NUM_CHANNELS]) begin
        found = 1'b1;
        win   = SW'((int'(last_grant) + k) % NUM_CHANNELS);
      end
    end
  end

  assign grant = found && out_ready && !clear;
  assign busy  = (|(~empty)) || out_set_stb;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_set_stb  <= 1'b0;
      out_set_addr <= '0;
      out_set_data <= '0;
      out_set_src  <= '0;
      overflow     <= '0;
      last_grant   <= LG_RST;
    end else if (clear) begin
      out_set_stb <= 1'b0;
      overflow    <= '0;
      last_grant  <= LG_RST;
    end else begin
      out_set_stb <= grant;
      if (grant) begin
        {out_set_addr, out_set_data} <= head[win];
        out_set_src                  <= win;
        last_grant                   <= win;
      end
      overflow <= overflow | (push & full & ~pop);
    end
  end

endmodule

// File: tb/tb_shared_set_bus_arbiter.sv
// Bench for shared_set_bus_arbiter: vector table, directed corner sequences and
// random traffic against a queue-based reference model.
module tb_shared_set_bus_arbiter;

  localparam int DEPTH = 4;
`ifdef SHARED_SET_ARB_ADDR_FILTER_EN
  localparam bit FILT = 1'b1;
`else
  localparam bit FILT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        clear = 1'b0;
  logic [1:0]  in_set_stb = '0;
  logic [15:0] in_set_addr = '0;
  logic [63:0] in_set_data = '0;
  logic        out_ready = 1'b0;
  logic        out_set_stb;
  logic [7:0]  out_set_addr;
  logic [31:0] out_set_data;
  logic        out_set_src;
  logic [1:0]  overflow;
  logic        busy;

  always #5 clk = ~clk;

  shared_set_bus_arbiter #(
    .NUM_CHANNELS(2), .AWIDTH(8), .DWIDTH(32), .FIFO_AWIDTH(2),
    .ADDR_LO(8'h80), .ADDR_HI(8'h8F)
  ) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear),
    .in_set_stb(in_set_stb), .in_set_addr(in_set_addr), .in_set_data(in_set_data),
    .out_set_stb(out_set_stb), .out_set_addr(out_set_addr), .out_set_data(out_set_data),
    .out_set_src(out_set_src), .out_ready(out_ready), .overflow(overflow), .busy(busy)
  );

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: one queue per channel plus the last granted channel.
  logic [39:0] mq [2][$];
  int          mlg;
  logic [1:0]  mov;
  logic        m_stb;
  logic [7:0]  m_addr;
  logic [31:0] m_data;
  logic        m_src;
  logic        m_busy;
  logic [39:0] seen [$];

  function automatic bit passes(input logic [7:0] a);
    return (a >= 8'h80 && a <= 8'h8F) || !FILT;
  endfunction

  task automatic model_reset();
    mq[0].delete(); mq[1].delete();
    mlg = 1; mov = '0; m_stb = 0; m_addr = '0; m_data = '0; m_src = 0; m_busy = 0;
  endtask

  task automatic step(input logic [1:0] s, input logic [7:0] a0, input logic [31:0] d0,
                      input logic [7:0] a1, input logic [31:0] d1, input logic r, input logic c);
    int          w;
    logic [39:0] e;
    logic [7:0]  aa [2];
    logic [31:0] dd [2];
    in_set_stb = s; in_set_addr = {a1, a0}; in_set_data = {d1, d0};
    out_ready = r; clear = c;
    aa[0] = a0; aa[1] = a1; dd[0] = d0; dd[1] = d1;
    if (c) begin
      mq[0].delete(); mq[1].delete();
      mov = '0; m_stb = 0; mlg = 1;
    end else begin
      w = -1;
      for (int k = 1; k <= 2; k++)
        if (w < 0 && mq[(mlg + k) % 2].size() > 0) w = (mlg + k) % 2;
      m_stb = 0;
      if (w >= 0 && r) begin
        e = mq[w].pop_front();
        m_addr = e[39:32]; m_data = e[31:0]; m_src = w[0]; m_stb = 1; mlg = w;
      end
      for (int i = 0; i < 2; i++)
        if (s[i] && passes(aa[i])) begin
          if (mq[i].size() < DEPTH) mq[i].push_back({aa[i], dd[i]});
          else mov[i] = 1'b1;
        end
    end
    m_busy = (mq[0].size() + mq[1].size() > 0) || m_stb;
    @(posedge clk); #1;
    if (out_set_stb) seen.push_back({out_set_addr, out_set_data});
    chk("m_stb", out_set_stb, m_stb);
    chk("m_addr", out_set_addr, m_addr);
    chk("m_data", out_set_data, m_data);
    chk("m_src", out_set_src, m_src);
    chk("m_ovf", overflow, mov);
    chk("m_busy", busy, m_busy);
  endtask

  task automatic idle(input logic r);
    step(2'b00, 8'h0, 32'h0, 8'h0, 32'h0, r, 1'b0);
  endtask

  typedef struct {
    logic [1:0] s; logic [7:0] a0; logic [31:0] d0; logic [7:0] a1; logic [31:0] d1;
    logic e_stb; logic [7:0] e_addr; logic [31:0] e_data; logic e_src; logic e_busy;
  } vec_t;
  vec_t tbl [15];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 5; i++) tbl[i] = '{2'b00, 8'h0, 32'h0, 8'h0, 32'h0, 1'b0, 8'h0, 32'h0, 1'b0, 1'b0};
    tbl[5]  = '{2'b10, 8'h0, 32'h0, 8'h10, 32'hDEADBEEF, 1'b0, 8'h0, 32'h0, 1'b0, 1'b1};
    tbl[6]  = '{2'b00, 8'h0, 32'h0, 8'h0, 32'h0, 1'b1, 8'h10, 32'hDEADBEEF, 1'b1, 1'b1};
    tbl[7]  = '{2'b00, 8'h0, 32'h0, 8'h0, 32'h0, 1'b0, 8'h10, 32'hDEADBEEF, 1'b1, 1'b0};
    tbl[8]  = '{2'b11, 8'h01, 32'h1, 8'h02, 32'h2, 1'b0, 8'h10, 32'hDEADBEEF, 1'b1, 1'b1};
    tbl[9]  = '{2'b00, 8'h0, 32'h0, 8'h0, 32'h0, 1'b1, 8'h01, 32'h1, 1'b0, 1'b1};
    tbl[10] = '{2'b00, 8'h0, 32'h0, 8'h0, 32'h0, 1'b1, 8'h02, 32'h2, 1'b1, 1'b1};
    tbl[11] = '{2'b11, 8'h03, 32'h3, 8'h04, 32'h4, 1'b0, 8'h02, 32'h2, 1'b1, 1'b1};
    tbl[12] = '{2'b00, 8'h0, 32'h0, 8'h0, 32'h0, 1'b1, 8'h03, 32'h3, 1'b0, 1'b1};
    tbl[13] = '{2'b00, 8'h0, 32'h0, 8'h0, 32'h0, 1'b1, 8'h04, 32'h4, 1'b1, 1'b1};
    tbl[14] = '{2'b00, 8'h0, 32'h0, 8'h0, 32'h0, 1'b0, 8'h04, 32'h4, 1'b1, 1'b0};

    model_reset();
    #12;
    chk("rst_stb", out_set_stb, 1'b0);
    chk("rst_addr", out_set_addr, 8'h0);
    chk("rst_data", out_set_data, 32'h0);
    chk("rst_src", out_set_src, 1'b0);
    chk("rst_ovf", overflow, 2'b00);
    chk("rst_busy", busy, 1'b0);
    @(negedge clk); reset_n = 1'b1;

    // Single write latency and RR rotation over two pairs.
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].s, tbl[i].a0, tbl[i].d0, tbl[i].a1, tbl[i].d1, 1'b1, 1'b0);
      chk($sformatf("vec%0d_stb", i), out_set_stb, tbl[i].e_stb);
      chk($sformatf("vec%0d_addr", i), out_set_addr, tbl[i].e_addr);
      chk($sformatf("vec%0d_data", i), out_set_data, tbl[i].e_data);
      chk($sformatf("vec%0d_src", i), out_set_src, tbl[i].e_src);
      chk($sformatf("vec%0d_busy", i), busy, tbl[i].e_busy);
    end

    // Backpressure: five writes into depth four.
    seen.delete();
    for (int k = 0; k < 5; k++) step(2'b01, 8'h20 + 8'(k), 32'd100 + 32'(k), 8'h0, 32'h0, 1'b0, 1'b0);
    chk("bp_ovf", overflow, 2'b01);
    chk("bp_nostb", seen.size(), 0);
    for (int k = 0; k < 8; k++) idle(1'b1);
    chk("bp_count", seen.size(), 4);
    for (int k = 0; k < 4; k++) if (k < seen.size()) chk("bp_order", seen[k][31:0], 32'd100 + 32'(k));
    step(2'b00, 8'h0, 32'h0, 8'h0, 32'h0, 1'b1, 1'b1);
    chk("clr_ovf", overflow, 2'b00);

    // Push on full with simultaneous pop.
    for (int k = 0; k < 4; k++) step(2'b01, 8'h30, 32'd200 + 32'(k), 8'h0, 32'h0, 1'b0, 1'b0);
    seen.delete();
    step(2'b01, 8'h30, 32'd204, 8'h0, 32'h0, 1'b1, 1'b0);
    chk("pof_ovf", overflow, 2'b00);
    for (int k = 0; k < 8; k++) idle(1'b1);
    chk("pof_count", seen.size(), 5);
    for (int k = 0; k < 5; k++) if (k < seen.size()) chk("pof_order", seen[k][31:0], 32'd200 + 32'(k));

    // clear mid-burst; the strobe during clear is discarded, pointer restarts at 0.
    for (int k = 0; k < 5; k++) step(2'b01, 8'h40, 32'd300 + 32'(k), 8'h0, 32'h0, 1'b0, 1'b0);
    chk("pre_clr_ovf", overflow, 2'b01);
    step(2'b10, 8'h0, 32'h0, 8'h55, 32'h55, 1'b1, 1'b1);
    chk("clr_stb", out_set_stb, 1'b0);
    chk("clr_ovf2", overflow, 2'b00);
    chk("clr_busy", busy, 1'b0);
    seen.delete();
    for (int k = 0; k < 4; k++) idle(1'b1);
    chk("clr_nostb", seen.size(), 0);
    step(2'b11, 8'h61, 32'h61, 8'h62, 32'h62, 1'b1, 1'b0);
    idle(1'b1);
    chk("clr_rr_stb", out_set_stb, 1'b1);
    chk("clr_rr_src0", out_set_src, 1'b0);
    idle(1'b1);
    chk("clr_rr_src1", out_set_src, 1'b1);
    idle(1'b1);

    // Address filter boundaries.
    seen.delete();
    step(2'b01, 8'h7F, 32'h700, 8'h0, 32'h0, 1'b1, 1'b0);
    step(2'b01, 8'h90, 32'h701, 8'h0, 32'h0, 1'b1, 1'b0);
    step(2'b01, 8'h85, 32'h702, 8'h0, 32'h0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) idle(1'b1);
    chk("flt_count", seen.size(), FILT ? 1 : 3);
    if (seen.size() > 0) chk("flt_last", seen[seen.size()-1], {8'h85, 32'h702});
    chk("flt_ovf", overflow, 2'b00);

    // Asynchronous reset while a transaction is on the bus.
    for (int k = 0; k < 3; k++) step(2'b11, 8'h8A, 32'h900 + 32'(k), 8'h8B, 32'h910 + 32'(k), 1'b0, 1'b0);
    idle(1'b1);
    chk("mid_stb_pre", out_set_stb, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_stb", out_set_stb, 1'b0);
    chk("mid_rst_addr", out_set_addr, 8'h0);
    chk("mid_rst_data", out_set_data, 32'h0);
    chk("mid_rst_busy", busy, 1'b0);
    model_reset();
    @(negedge clk); reset_n = 1'b1;

    // Random traffic against the model.
    for (int n = 0; n < 1500; n++) begin
      step(2'($urandom_range(0, 3)),
           8'h78 + 8'($urandom_range(0, 31)), $urandom,
           8'h78 + 8'($urandom_range(0, 31)), $urandom,
           $urandom_range(0, 9) < 7, $urandom_range(0, 99) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
